if_id_fetch: RTL

- Instruction-fetch stage plus IF/ID pipeline register of the 5-stage MIPS core.
- Holds the PC, drives instruction-memory address, latches fetched word into IF_ID_instr / IF_ID_pc4.
- Consumes the ID-stage branch comparator result (compare_i) and register operand rs1_i to redirect on taken branches, j/jal, jr/jalr, and on exception/eret redirects.
- Downstream: ID decode, branch comparator, register file.

---
 rtl/if_id_fetch.sv | 106 ++++++++++
 1 files changed

// File: rtl/if_id_fetch.sv
// Instruction-fetch stage and IF/ID pipeline register for the 5-stage MIPS core.
// Resolves branches, jumps and register jumps in ID and redirects the PC.
module if_id_fetch #(
  parameter logic [31:0] RESET_PC   = 32'h0000_3000,
  parameter int          DELAY_SLOT = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        compare_i,
  input  logic [31:0] rs1_i,
  input  logic        exc_redirect,
  input  logic [31:0] exc_target,
  input  logic [31:0] imem_rdata,
  output logic [31:0] imem_addr,
  output logic [31:0] IF_ID_instr,
  output logic [31:0] IF_ID_pc4,
  output logic        IF_ID_valid,
  output logic        redirect_o
);

  logic [31:0] pc_reg, pc_next;
  logic [31:0] instr_reg, instr_next;
  logic [31:0] pc4_reg, pc4_next;
  logic        valid_reg, valid_next;

  logic [31:0] pc_plus4;
  logic [5:0]  opcode;
  logic [5:0]  funct;
  logic        is_branch, is_jump, is_jreg;
  logic        id_redir;
  logic [31:0] br_tgt, j_tgt, jr_tgt, redir_tgt;
  logic        unused_rs1_low;

  assign pc_plus4 = pc_reg + 32'd4;
  assign opcode   = instr_reg[31:26];
  assign funct    = instr_reg[5:0];

  assign is_branch = (opcode == 6'h04) || (opcode == 6'h05) || (opcode == 6'h06) ||
                     (opcode == 6'h07) || (opcode == 6'h01);
  assign is_jump   = (opcode == 6'h02) || (opcode == 6'h03);
  assign is_jreg   = (opcode == 6'h00) && ((funct == 6'h08) || (funct == 6'h09));

  assign id_redir = valid_reg & ((is_branch & compare_i) | is_jump | is_jreg);

  assign br_tgt = pc4_reg + {{14{instr_reg[15]}}, instr_reg[15:0], 2'b00};
  assign j_tgt  = {pc4_reg[31:28], instr_reg[25:0], 2'b00};
  // Misaligned register targets are silently truncated to a word boundary.
  assign jr_tgt = {rs1_i[31:2], 2'b00};
  assign unused_rs1_low = ^rs1_i[1:0];

  always_comb begin
    redir_tgt = br_tgt;
    if (is_jreg)
      redir_tgt = jr_tgt;
    else if (is_jump)
      redir_tgt = j_tgt;
  end

  always_comb begin
    pc_next    = pc_plus4;
    instr_next = imem_rdata;
    pc4_next   = pc_plus4;
    valid_next = 1'b1;
    if (exc_redirect) begin
      pc_next    = exc_target;
      instr_next = 32'd0;
      pc4_next   = 32'd0;
      valid_next = 1'b0;
    end else if (stall) begin
      // Comparator operands are not ready; the redirect re-evaluates after the stall.
      pc_next    = pc_reg;
      instr_next = instr_reg;
      pc4_next   = pc4_reg;
      valid_next = valid_reg;
    end else if (id_redir) begin
      pc_next = redir_tgt;
      if (DELAY_SLOT == 0) begin
        instr_next = 32'd0;
        pc4_next   = 32'd0;
        valid_next = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_reg    <= RESET_PC;
      instr_reg <= 32'd0;
      pc4_reg   <= 32'd0;
      valid_reg <= 1'b0;
    end else begin
      pc_reg    <= pc_next;
      instr_reg <= instr_next;
      pc4_reg   <= pc4_next;
      valid_reg <= valid_next;
    end
  end

  assign imem_addr   = pc_reg;
  assign IF_ID_instr = instr_reg;
  assign IF_ID_pc4   = pc4_reg;
  assign IF_ID_valid = valid_reg;
  assign redirect_o  = exc_redirect | (id_redir & ~stall);

endmodule
